// File: rtl/mips16_ctrl_pkg.sv
// mips16_ctrl_pkg
// Shared types and constants for the MIPS16 run controller.
//   ctrl_state_e : controller FSM states
//   ST_*         : run result codes reported on status_o
//   RST_CYC_DEF  : default core reset hold window in cycles
//   sat_inc16    : saturating 16-bit increment used by the run counter
package mips16_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RST_HOLD = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4
  } ctrl_state_e;

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_HALT  = 2'b01;
  localparam logic [1:0] ST_LIMIT = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  localparam int unsigned RST_CYC_DEF = 2;

  // Sticks at 0xFFFF instead of wrapping so a runaway program reads as "very long".
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mips16_halt_det.sv
// mips16_halt_det
// Detects the core parking on its halt self-jump: the PC equals halt_pc in two
// consecutive RUN cycles.
//   clk_i      : system clock
//   reset_i    : synchronous active-high reset
//   run_i      : controller is in RUN this cycle
//   pc_i       : core program counter
//   halt_pc_i  : PC value that means "halted"
//   halt_o     : combinational flag, second consecutive match seen this cycle
module mips16_halt_det (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        run_i,
  input  logic [15:0] pc_i,
  input  logic [15:0] halt_pc_i,
  output logic        halt_o
);

  logic [15:0] prev_pc_q;
  logic        prev_valid_q;

  // The valid flag tracks "last cycle was also RUN", so the first RUN cycle of a
  // run never compares against a stale PC from an earlier run.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_pc_q    <= 16'h0000;
      prev_valid_q <= 1'b0;
    end else begin
      prev_pc_q    <= pc_i;
      prev_valid_q <= run_i;
    end
  end

  assign halt_o = run_i & prev_valid_q & (prev_pc_q == halt_pc_i) & (pc_i == halt_pc_i);

endmodule

// File: rtl/mips16_run_ctrl.sv
// mips16_run_ctrl
// Sequences the 16-bit single-cycle MIPS core: loads a program into IMEM from a
// valid/ready word stream, holds the core in reset for RST_CYC cycles, runs it
// while counting cycles, and stops on halt, cycle limit or abort.
//   clk_i, reset_i        : clock, synchronous active-high reset
//   start_i               : start pulse, honoured only in IDLE
//   prog_len_i            : words to load (0 skips load, saturates at 2^IMEM_AW)
//   run_limit_i           : max RUN cycles, 0 = unlimited
//   halt_pc_i             : PC that signals halt
//   abort_i               : level abort from LOAD/RST_HOLD/RUN
//   ld_valid_i, ld_data_i : program word stream in
//   ld_ready_o            : stream ready (LOAD state)
//   imem_we_o/addr_o/wdata_o : IMEM write port
//   core_reset_o          : core reset, low only in RUN
//   pc_in_i               : core PC
//   busy_o, done_o        : activity flag, one-cycle end-of-run pulse
//   status_o              : result code (none/halt/limit/abort)
//   cycle_count_o         : RUN cycles of the last or current run
module mips16_run_ctrl
  import mips16_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_AW = 4,
  parameter int unsigned RST_CYC = RST_CYC_DEF
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [IMEM_AW:0]   prog_len_i,
  input  logic [15:0]        run_limit_i,
  input  logic [15:0]        halt_pc_i,
  input  logic               abort_i,
  input  logic               ld_valid_i,
  input  logic [15:0]        ld_data_i,
  output logic               ld_ready_o,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [15:0]        imem_wdata_o,
  output logic               core_reset_o,
  input  logic [15:0]        pc_in_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [1:0]         status_o,
  output logic [15:0]        cycle_count_o
);

  localparam int unsigned LW   = IMEM_AW + 1;
  localparam int unsigned RH_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [LW-1:0]   MAX_LEN = LW'(1) << IMEM_AW;
  localparam logic [RH_W-1:0] RH_LOAD = RH_W'(RST_CYC - 1);

  ctrl_state_e     state_q, state_d;
  logic [LW-1:0]   word_cnt_q;
  logic [LW-1:0]   len_q;
  logic [15:0]     limit_q;
  logic [RH_W-1:0] rh_cnt_q;
  logic            core_reset_q;
  logic            busy_q;
  logic            done_q;
  logic [1:0]      status_q;
  logic [15:0]     count_q;

  logic [LW-1:0]   len_sat;
  logic [15:0]     count_inc;
  logic            in_load;
  logic            in_run;
  logic            halt_hit;
  logic            limit_hit;
  logic            last_word;
  logic [1:0]      stop_code;

  assign len_sat   = (prog_len_i > MAX_LEN) ? MAX_LEN : prog_len_i;
  assign count_inc = sat_inc16(count_q);
  assign in_load   = (state_q == LOAD);
  assign in_run    = (state_q == RUN);
  assign limit_hit = (limit_q != 16'h0000) && (count_inc == limit_q);
  assign last_word = (word_cnt_q == len_q - LW'(1));

  assign ld_ready_o   = in_load;
  assign imem_we_o    = ld_valid_i & in_load;
  assign imem_addr_o  = word_cnt_q[IMEM_AW-1:0];
  assign imem_wdata_o = in_load ? ld_data_i : 16'h0000;

  assign core_reset_o  = core_reset_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign status_o      = status_q;
  assign cycle_count_o = count_q;

  mips16_halt_det u_halt_det (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .run_i     (in_run),
    .pc_i      (pc_in_i),
    .halt_pc_i (halt_pc_i),
    .halt_o    (halt_hit)
  );

  // Next-state decode. Stop reasons are checked abort first, then halt, then
  // limit, so the highest-priority reason wins when several coincide.
  always_comb begin
    state_d   = state_q;
    stop_code = ST_NONE;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = (len_sat == '0) ? RST_HOLD : LOAD;
      end
      LOAD: begin
        if (abort_i) begin
          state_d   = DONE;
          stop_code = ST_ABORT;
        end else if (ld_valid_i && last_word) begin
          state_d = RST_HOLD;
        end
      end
      RST_HOLD: begin
        if (abort_i) begin
          state_d   = DONE;
          stop_code = ST_ABORT;
        end else if (rh_cnt_q == '0) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d   = DONE;
          stop_code = ST_ABORT;
        end else if (halt_hit) begin
          state_d   = DONE;
          stop_code = ST_HALT;
        end else if (limit_hit) begin
          state_d   = DONE;
          stop_code = ST_LIMIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller registers. The visible flags are computed from the next state so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      len_q        <= '0;
      limit_q      <= 16'h0000;
      rh_cnt_q     <= RH_LOAD;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      status_q     <= ST_NONE;
      count_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      core_reset_q <= (state_d != RUN);
      busy_q       <= (state_d == LOAD) || (state_d == RST_HOLD) || (state_d == RUN);
      done_q       <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start_i) begin
            len_q      <= len_sat;
            limit_q    <= run_limit_i;
            count_q    <= 16'h0000;
            status_q   <= ST_NONE;
            word_cnt_q <= '0;
            rh_cnt_q   <= RH_LOAD;
          end
        end
        LOAD: begin
          if (imem_we_o) word_cnt_q <= word_cnt_q + LW'(1);
        end
        RST_HOLD: begin
          if (rh_cnt_q != '0) rh_cnt_q <= rh_cnt_q - RH_W'(1);
        end
        RUN: begin
          count_q <= count_inc;
        end
        default: begin
        end
      endcase
      if ((state_d == DONE) && (state_q != DONE)) status_q <= stop_code;
    end
  end

endmodule

// File: tb/tb_mips16_run_ctrl.sv
// tb_mips16_run_ctrl
// Directed bench for the MIPS16 run controller: load/halt, cycle limit,
// stalled stream with abort, skipped load with halt-vs-limit priority, and a
// reset in the middle of a run.
module tb_mips16_run_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort, ldValid;
  logic [4:0]  progLen;
  logic [15:0] runLimit, haltPc, ldData, pcIn;
  logic        ldReady, imemWe, coreReset, busy, done;
  logic [3:0]  imemAddr;
  logic [15:0] imemWdata, cycleCount;
  logic [1:0]  status;

  int checks = 0;
  int errors = 0;

  logic [15:0] prog [3] = '{16'h1111, 16'h2222, 16'h3333};

  always #5 clk = ~clk;

  mips16_run_ctrl dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .prog_len_i    (progLen),
    .run_limit_i   (runLimit),
    .halt_pc_i     (haltPc),
    .abort_i       (abort),
    .ld_valid_i    (ldValid),
    .ld_data_i     (ldData),
    .ld_ready_o    (ldReady),
    .imem_we_o     (imemWe),
    .imem_addr_o   (imemAddr),
    .imem_wdata_o  (imemWdata),
    .core_reset_o  (coreReset),
    .pc_in_i       (pcIn),
    .busy_o        (busy),
    .done_o        (done),
    .status_o      (status),
    .cycle_count_o (cycleCount)
  );

  // Counts every comparison and reports any that disagree.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advances one clock and settles just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle start pulse with the given run setup.
  task automatic applyStimulus(input logic [4:0] len, input logic [15:0] lim, input logic [15:0] hpc);
    progLen  = len;
    runLimit = lim;
    haltPc   = hpc;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; ldValid = 1'b0;
    progLen = '0; runLimit = '0; haltPc = '0; ldData = '0; pcIn = '0;
    tick();
    tick();
    checkOutput("rst_core_reset", coreReset, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_status", status, 0);
    checkOutput("rst_count", cycleCount, 0);
    checkOutput("rst_ld_ready", ldReady, 0);
    checkOutput("rst_we", imemWe, 0);
    reset = 1'b0;
    tick();

    // Load three words back to back, then halt on PC 0x0006
    $display("[TB] load and halt");
    applyStimulus(5'd3, 16'd0, 16'h0006);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_ld_ready", ldReady, 1);
    for (int i = 0; i < 3; i++) begin
      ldValid = 1'b1;
      ldData  = prog[i];
      #1;
      checkOutput("t1_we", imemWe, 1);
      checkOutput("t1_addr", imemAddr, i);
      checkOutput("t1_wdata", imemWdata, prog[i]);
      tick();
    end
    ldValid = 1'b0;
    #1;
    checkOutput("t1_hold1_core_reset", coreReset, 1);
    checkOutput("t1_hold1_we", imemWe, 0);
    checkOutput("t1_hold1_ld_ready", ldReady, 0);
    tick();
    checkOutput("t1_hold2_core_reset", coreReset, 1);
    tick();
    checkOutput("t1_run_core_reset", coreReset, 0);
    checkOutput("t1_run_count0", cycleCount, 0);
    for (int c = 1; c <= 5; c++) begin
      pcIn = (c >= 4) ? 16'h0006 : 16'h0002;
      if (c < 5) begin
        #1;
        checkOutput("t2_run_busy", busy, 1);
        checkOutput("t2_run_done", done, 0);
      end
      tick();
    end
    pcIn = 16'h0000;
    checkOutput("t2_done", done, 1);
    checkOutput("t2_status", status, 2'b01);
    checkOutput("t2_count", cycleCount, 5);
    checkOutput("t2_core_reset", coreReset, 1);
    checkOutput("t2_busy", busy, 0);
    tick();
    checkOutput("t2_done_clear", done, 0);
    checkOutput("t2_status_hold", status, 2'b01);
    checkOutput("t2_count_hold", cycleCount, 5);

    // One-word load, then stop on a cycle limit of 10
    $display("[TB] cycle limit");
    applyStimulus(5'd1, 16'd10, 16'h00FF);
    checkOutput("t3_status_clear", status, 0);
    checkOutput("t3_count_clear", cycleCount, 0);
    ldValid = 1'b1;
    ldData  = 16'hABCD;
    #1;
    checkOutput("t3_we", imemWe, 1);
    checkOutput("t3_addr", imemAddr, 0);
    tick();
    ldValid = 1'b0;
    tick();
    tick();
    checkOutput("t3_run_core_reset", coreReset, 0);
    for (int c = 1; c <= 10; c++) begin
      pcIn = 16'h0010 + 16'(c);
      if (c == 9) begin
        #1;
        checkOutput("t3_not_done_early", done, 0);
      end
      tick();
    end
    checkOutput("t3_done", done, 1);
    checkOutput("t3_status", status, 2'b10);
    checkOutput("t3_count", cycleCount, 10);
    tick();

    // Stalled stream then abort during LOAD
    $display("[TB] stall and abort");
    applyStimulus(5'd4, 16'd0, 16'hFFFF);
    ldValid = 1'b1; ldData = 16'h00A0;
    #1;
    checkOutput("t4_we0", imemWe, 1);
    checkOutput("t4_addr0", imemAddr, 0);
    checkOutput("t4_core_reset_a", coreReset, 1);
    tick();
    ldValid = 1'b0;
    #1;
    checkOutput("t4_we_gap", imemWe, 0);
    tick();
    ldValid = 1'b1; ldData = 16'h00A1;
    #1;
    checkOutput("t4_we1", imemWe, 1);
    checkOutput("t4_addr1", imemAddr, 1);
    checkOutput("t4_wdata1", imemWdata, 16'h00A1);
    tick();
    ldValid = 1'b0; abort = 1'b1;
    #1;
    checkOutput("t4_ready_pre_abort", ldReady, 1);
    checkOutput("t4_addr_after2", imemAddr, 2);
    checkOutput("t4_core_reset_b", coreReset, 1);
    tick();
    abort = 1'b0;
    checkOutput("t4_ready_after", ldReady, 0);
    checkOutput("t4_done", done, 1);
    checkOutput("t4_status", status, 2'b11);
    checkOutput("t4_core_reset_c", coreReset, 1);
    tick();
    checkOutput("t4_idle_busy", busy, 0);

    // Skip the load; halt and limit coincide on cycle 5, halt wins
    $display("[TB] skip load and priority");
    ldValid = 1'b1; ldData = 16'hDEAD;
    applyStimulus(5'd0, 16'd5, 16'h0006);
    #1;
    checkOutput("t5_busy", busy, 1);
    checkOutput("t5_ld_ready", ldReady, 0);
    checkOutput("t5_we", imemWe, 0);
    checkOutput("t5_core_reset", coreReset, 1);
    tick();
    ldValid = 1'b0;
    tick();
    checkOutput("t5_run_core_reset", coreReset, 0);
    for (int c = 1; c <= 5; c++) begin
      pcIn = (c >= 4) ? 16'h0006 : 16'h0004;
      tick();
    end
    pcIn = 16'h0000;
    checkOutput("t5_done", done, 1);
    checkOutput("t5_status", status, 2'b01);
    checkOutput("t5_count", cycleCount, 5);
    tick();

    // Reset during RUN cycle 3, with a start pulse in the same cycle
    $display("[TB] mid-run reset");
    applyStimulus(5'd0, 16'd0, 16'h0006);
    tick();
    tick();
    tick();
    tick();
    checkOutput("t6_in_run", coreReset, 0);
    checkOutput("t6_count_pre", cycleCount, 2);
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    checkOutput("t6_core_reset", coreReset, 1);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_status", status, 0);
    checkOutput("t6_count", cycleCount, 0);
    checkOutput("t6_done", done, 0);
    tick();
    checkOutput("t6_start_ignored", busy, 0);
    checkOutput("t6_ld_ready", ldReady, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips16_run_ctrl.md
Name: mips16_run_ctrl

Overview:
Run controller that sequences the 16-bit single-cycle MIPS core for bring-up and regression.
- Load phase: accepts a program as a valid/ready word stream and writes it into instruction memory.
- Reset and run phases: holds the core in reset for a fixed window, releases it, and counts run cycles.
- Stop conditions: halt (PC parked on a self-jump), cycle limit, or abort.
- Sits between the bench/host loader and the mips_16 instance; it drives the core's reset and the IMEM write port.

Parameters:
- IMEM_AW, 4, instruction memory word-address width (2^IMEM_AW words).
- RST_CYC, 2, number of cycles core_reset is held after loading, before the run starts (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- start  in  1  single-cycle pulse; honoured only in IDLE.
- prog_len  in  IMEM_AW+1  words to load; 0 skips the load phase; values above 2^IMEM_AW saturate to 2^IMEM_AW.
- run_limit  in  16  maximum RUN cycles; 0 = unlimited.
- halt_pc  in  16  PC value that signals halt.
- abort  in  1  level; forces an abort-stop from LOAD, RST_HOLD or RUN.
- ld_valid  in  1  program word valid.
- ld_data  in  16  program word.
- ld_ready  out  1  program word accepted this cycle when ld_valid is also high.
- imem_we  out  1  IMEM write strobe.
- imem_addr  out  IMEM_AW  IMEM word address.
- imem_wdata  out  16  IMEM write data.
- core_reset  out  1  drives mips_16 reset.
- pc_in  in  16  mips_16 pc_out.
- busy  out  1  high in LOAD, RST_HOLD and RUN.
- done  out  1  one-cycle pulse when a run ends.
- status  out  2  result code: 00 none, 01 halt, 10 limit, 11 abort.
- cycle_count  out  16  number of RUN cycles in the last or current run.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, core_reset=1, ld_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, status=00, cycle_count=0. Reset wins over every other input, including mid-LOAD and mid-RUN. A reset during RUN returns core_reset to 1 on the next edge.
- States: IDLE, LOAD, RST_HOLD, RUN, DONE.
- core_reset=0 only in RUN; it is 1 in every other state.
- IDLE:
  - On start: latch prog_len and run_limit, clear cycle_count, set status=00.
  - Next state is LOAD, or RST_HOLD if prog_len==0.
  - start in any other state is ignored.
- LOAD:
  - ld_ready=1.
  - imem_we is combinational: ld_valid & ld_ready. imem_addr = word counter; imem_wdata = ld_data.
  - The counter increments on each handshake. The handshake on word prog_len-1 moves to RST_HOLD at that edge.
  - Gaps in ld_valid stall with no write.
- RST_HOLD: stays exactly RST_CYC cycles (down-counter), then RUN.
- RUN:
  - cycle_count increments every RUN cycle and saturates at 0xFFFF.
  - Halt: pc_in==halt_pc in two consecutive RUN cycles. The first RUN cycle has no valid previous PC.
  - Limit: run_limit!=0 and the incremented count equals run_limit, so the final cycle_count equals run_limit.
- Stop priority when several occur in the same cycle: abort > halt > limit.
  - The chosen status is registered at the transition into DONE.
  - abort in LOAD or RST_HOLD also goes to DONE with status 11; partial IMEM contents are left as written.
- DONE: done=1 for one cycle, then IDLE. status and cycle_count hold until the next accepted start.
- busy=1 exactly in LOAD, RST_HOLD and RUN.
- All outputs are registered except imem_we, imem_addr, imem_wdata and ld_ready, which are decoded from state and counter.

Decomposition:
- Package mips16_ctrl_pkg:
  - State enum: IDLE, LOAD, RST_HOLD, RUN, DONE.
  - Status constants: ST_NONE=2'b00, ST_HALT=2'b01, ST_LIMIT=2'b10, ST_ABORT=2'b11.
  - Default RST_CYC.
- One natural sub-module: mips16_halt_det.
  - Registers the previous PC and a valid flag.
  - Flags pc_in==halt_pc on two consecutive cycles.
  - Valid flag clears whenever the controller is not in RUN.

Test Plan:
1. Load and halt: start, prog_len=3, stream 0x1111,0x2222,0x3333 back-to-back -> imem_we high 3 cycles at addr 0,1,2 with that data; core_reset stays 1 for 2 cycles after the last write, then drops.
2. Halt detection: halt_pc=0x0006; model pc_in=0x0006 in RUN cycles 4 and 5 -> leave RUN after cycle 5, done pulse next cycle, status=01, cycle_count=5, core_reset back to 1.
3. Cycle limit: run_limit=10, pc_in never equals halt_pc -> exit after 10 RUN cycles, status=10, cycle_count=10.
4. Stream stall and abort: prog_len=4, ld_valid toggles 1,0,1 -> only 2 writes at addr 0,1; assert abort -> ld_ready=0 next cycle, done pulse, status=11, core_reset never deasserts.
5. Skip load and priority: prog_len=0 -> IDLE to RST_HOLD directly with no imem_we. Then run_limit=5 with the halt condition also met on cycle 5 -> status=01 (halt beats limit).
6. Mid-run reset: assert reset during RUN cycle 3 -> next edge state=IDLE, core_reset=1, busy=0, status=00, cycle_count=0. A start pulse given in the reset cycle is ignored.
